matmul_sequencer: RTL
=====================

Name: matmul_sequencer

Overview:
- Sequences a single shared 4x4-bit combinational multiplier to compute C = A x B for NxN matrices of unsigned 4-bit elements.
- Issues one multiply-accumulate per clock and writes each finished dot product into a result register bank.
- Sits between the host/control logic (start/done handshake, flat operand buses) and the existing gate-level `multiplier` datapath.

Parameters:
- N, 2, matrix dimension; legal range 2..4.
- ACC_W, 8+$clog2(N), result element width; holds the worst case N*15*15 with no overflow (N=2 gives 9).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new multiply; honoured only in IDLE.
- a_flat  input  N*N*4  matrix A; element (r,c) at bits [(r*N+c)*4 +: 4].
- b_flat  input  N*N*4  matrix B; same packing as A.
- busy  output  1  high while operands are held and MACs are in progress.
- done  output  1  one-cycle pulse when C is complete and valid.
- c_flat  output  N*N*ACC_W  matrix C; element (r,c) at [(r*N+c)*ACC_W +: ACC_W].

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, c_flat=0, indices i=j=k=0, accumulator=0.
- FSM states:
  - IDLE -> MAC on start=1.
  - MAC -> DONE after the last MAC.
  - DONE -> IDLE unconditionally after 1 cycle.
- Start acceptance (edge E0, IDLE with start=1):
  - Capture a_flat and b_flat into internal registers; later input changes are ignored.
  - Clear c_flat to 0, set busy=1, set i=j=k=0.
- MAC cycle:
  - Multiplier inputs are A[i][k] and B[k][j] from the captured registers; product is 8-bit, zero-extended to ACC_W.
  - acc <= (k==0) ? prod : acc+prod.
  - When k==N-1, write acc_next into C[i][j].
- Iteration order: k innermost, then j, then i; exactly N^3 MAC cycles.
- Timing: the last MAC happens at edge E(N^3). At that edge busy<=0, done<=1, state<=DONE. done is high for exactly one cycle (edges E(N^3)..E(N^3+1)).
- c_flat: each element becomes stable once written and holds until the next accepted start or reset.
- start while in MAC or DONE is ignored, with no queuing. The earliest new acceptance is in the cycle after done falls.
- rst during MAC or DONE: everything returns to reset values at the next edge, c_flat is cleared, and no done pulse is produced.
- Arithmetic is unsigned with no saturation; ACC_W sizing guarantees no wrap.

Optional Feature:
- Macro: MATMUL_PERF_CNT_EN.
- Defined:
  - Adds output perf_cnt (16 bits, reset 0), which increments by 1 on each done pulse and wraps 0xFFFF -> 0.
  - rst clears perf_cnt.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package matmul_pkg:
  - Element width constant (4) and product width constant (8).
  - FSM state typedef {IDLE, MAC, DONE} as a 2-bit enum.
  - Function for the flat-bus element offset.
- Sub-module: instantiate the existing `multiplier` (n1, n2 -> op[7:0]) once as the shared datapath.
- The indices, accumulator and FSM stay in matmul_sequencer; no further sub-modules.

Test Plan:
- N=2, A=identity (a_flat=16'h1001), b_flat=16'h4321: done exactly 8 cycles after the start edge; C elements (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4.
- N=2, all elements 15: every C element = 450 (9'h1C2), no overflow.
- N=2, A=16'h4321, B=16'h8765: C(0,0)=1*5+2*7=19, C(0,1)=1*6+2*8=22, C(1,0)=3*5+4*7=43, C(1,1)=3*6+4*8=50.
- Operand change and repeated start during busy: change a_flat and pulse start at cycle 3. Expected: result reflects the captured operands, a single done pulse, busy unaffected.
- rst asserted at MAC cycle 5: next cycle state=IDLE, busy=0, c_flat=0, no done pulse. A following start computes correctly.
- MATMUL_PERF_CNT_EN defined: three back-to-back operations (start held high) give perf_cnt=3, with exactly one idle cycle between done and the next busy. Preload perf_cnt=0xFFFF via forced state, then one more operation gives perf_cnt=0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: operand/product widths,
// FSM state encoding and the flat-bus element offset helper.
package matmul_pkg;

    localparam int ELEM_W = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of element (row, col) in a row-major flat bus of n x n elements.
    function automatic int elem_offset(input int row, input int col, input int n, input int width);
        return (row * n + col) * width;
    endfunction

endpackage

// File: rtl/matmul_sequencer_multiplier.sv
// Shared 4x4-bit unsigned array multiplier (n1 * n2 -> op), built from
// AND-gate partial products summed by rows of ripple-carry adders.
module multiplier (
    input  logic [3:0] n1,
    input  logic [3:0] n2,
    output logic [7:0] op
);

    logic [3:0] pp0;
    logic [3:0] pp1;
    logic [3:0] pp2;
    logic [3:0] pp3;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [4:0] s3;

    function automatic logic [4:0] ripple_add4(input logic [3:0] x, input logic [3:0] y);
        logic       c;
        logic [4:0] s;
        c = 1'b0;
        s = '0;
        for (int b = 0; b < 4; b++) begin
            s[b] = x[b] ^ y[b] ^ c;
            c    = (x[b] & y[b]) | (c & (x[b] ^ y[b]));
        end
        s[4] = c;
        return s;
    endfunction

    assign pp0 = n1 & {4{n2[0]}};
    assign pp1 = n1 & {4{n2[1]}};
    assign pp2 = n1 & {4{n2[2]}};
    assign pp3 = n1 & {4{n2[3]}};

    // Each row retires its LSB as a product bit and passes the upper bits on.
    assign s1 = ripple_add4({1'b0, pp0[3:1]}, pp1);
    assign s2 = ripple_add4(s1[4:1], pp2);
    assign s3 = ripple_add4(s2[4:1], pp3);

    assign op = {s3, s2[0], s1[0], pp0[0]};

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one shared 4x4 multiplier to compute C = A x B, one MAC per clock.
// Optional MATMUL_PERF_CNT_EN adds a 16-bit completed-operation counter.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N     = 2,
    parameter int ACC_W = 8 + $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N*N*ELEM_W-1:0]    a_flat,
    input  logic [N*N*ELEM_W-1:0]    b_flat,
    output logic                     busy,
    output logic                     done,
    output logic [N*N*ACC_W-1:0]     c_flat
`ifdef MATMUL_PERF_CNT_EN
    ,
    output logic [15:0]              perf_cnt
`endif
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t                    state;
    state_t                    state_next;
    logic [N*N*ELEM_W-1:0]     a_q;
    logic [N*N*ELEM_W-1:0]     b_q;
    logic [N*N*ACC_W-1:0]      c_q;
    logic [ACC_W-1:0]          acc_q;
    logic [ACC_W-1:0]          acc_next;
    logic [ACC_W-1:0]          prod_ext;
    logic [IDX_W-1:0]          i_q;
    logic [IDX_W-1:0]          j_q;
    logic [IDX_W-1:0]          k_q;
    logic [ELEM_W-1:0]         mul_n1;
    logic [ELEM_W-1:0]         mul_n2;
    logic [PROD_W-1:0]         prod;
    logic                      last_mac;

    multiplier u_mul (
        .n1 (mul_n1),
        .n2 (mul_n2),
        .op (prod)
    );

    // Operand selection from the captured copies, so host bus changes mid-run are invisible.
    always_comb begin
        mul_n1   = a_q[elem_offset(int'(i_q), int'(k_q), N, ELEM_W) +: ELEM_W];
        mul_n2   = b_q[elem_offset(int'(k_q), int'(j_q), N, ELEM_W) +: ELEM_W];
        prod_ext = {{(ACC_W - PROD_W){1'b0}}, prod};
        acc_next = (k_q == '0) ? prod_ext : acc_q + prod_ext;
        last_mac = (i_q == LAST_IDX) && (j_q == LAST_IDX) && (k_q == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (last_mac) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Index walk is k innermost, then j, then i; C[i][j] lands on the final k of each dot product.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a_flat;
                        b_q   <= b_flat;
                        c_q   <= '0;
                        acc_q <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_next;
                    if (k_q == LAST_IDX) begin
                        c_q[elem_offset(int'(i_q), int'(j_q), N, ACC_W) +: ACC_W] <= acc_next;
                        k_q <= '0;
                        if (j_q == LAST_IDX) begin
                            j_q <= '0;
                            i_q <= (i_q == LAST_IDX) ? '0 : i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state == MAC);
    assign done   = (state == DONE);
    assign c_flat = c_q;

`ifdef MATMUL_PERF_CNT_EN
    logic [15:0] perf_cnt_q;

    // Counts as the done pulse is launched; the 16-bit add wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= '0;
        end else if (state == MAC && last_mac) begin
            perf_cnt_q <= perf_cnt_q + 16'd1;
        end
    end

    assign perf_cnt = perf_cnt_q;
`endif

endmodule
